// File: rtl/prach_buffer_reader.sv
// PRACH capture buffer read controller: acknowledges the buffer's done request,
// reads every captured IQ word through the fixed-latency read port and streams
// the samples in address order through a credit-limited skid FIFO.
module prach_buffer_reader #(
  parameter int unsigned NUM_SAMPLES = 1536,
  parameter int unsigned RD_LATENCY  = 3,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_req,
  output logic        done_ack,
  output logic [10:0] rd_addr,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  output logic [15:0] dout_dr,
  output logic [15:0] dout_di,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy
);

  localparam int unsigned CntW  = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FcntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StAck, StRead, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [10:0]         rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_last_q, rd_last_d;
  logic [RD_LATENCY-1:0] en_pipe_q, last_pipe_q;

  logic [32:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0]    fifo_cnt_q;
  logic [32:0]         head;

  int unsigned         outstanding;
  logic                push, pop, issue_ok, last_addr, pipe_idle;

  // Credit: FIFO entries plus every read already issued but not yet written.
  always_comb begin
    outstanding = 32'(fifo_cnt_q) + 32'(rd_en_q);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      outstanding = outstanding + 32'(en_pipe_q[i]);
    end
  end

  assign issue_ok   = (state_q == StRead) && (outstanding < FIFO_DEPTH);
  assign last_addr  = (cnt_q == CntW'(NUM_SAMPLES - 1));
  assign pipe_idle  = !rd_en_q && (en_pipe_q == '0);
  assign push       = en_pipe_q[RD_LATENCY-1];
  assign dout_valid = (fifo_cnt_q != '0);
  assign pop        = dout_valid && dout_ready;

  // Next-state and read-issue decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (done_req) state_d = StAck;
      end
      StAck: begin
        cnt_d   = '0;
        state_d = StRead;
      end
      StRead: begin
        if (issue_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = 11'(cnt_q);
          rd_last_d = last_addr;
          cnt_d     = cnt_q + 1'b1;
          if (last_addr) state_d = StDrain;
        end
      end
      StDrain: begin
        // fifo empty implies the last beat has already been accepted
        if (pipe_idle && (fifo_cnt_q == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, read counter and registered read-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      rd_last_q <= rd_last_d;
    end
  end

  // In-flight tracking: enable and last tag travel alongside the read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe_q   <= '0;
      last_pipe_q <= '0;
    end else begin
      for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
        en_pipe_q[i]   <= en_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      en_pipe_q[0]   <= rd_en_q;
      last_pipe_q[0] <= rd_last_q;
    end
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // Skid FIFO storage: {last, di, dr}.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {last_pipe_q[RD_LATENCY-1], rd_data};
  end

  assign head      = fifo_mem_q[rd_ptr_q];
  // Gate payload with valid so outputs read as zero whenever nothing is offered.
  assign dout_dr   = dout_valid ? head[15:0]  : '0;
  assign dout_di   = dout_valid ? head[31:16] : '0;
  assign dout_last = dout_valid && head[32];

  assign done_ack  = (state_q == StAck);
  assign busy      = (state_q != StIdle);
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_prach_buffer_reader.sv
// Bench for prach_buffer_reader: default-size instance driven by a table of
// frame scenarios plus a reset-mid-frame sequence, and a 4-sample instance for
// the small-FIFO boundary.
module tb_prach_buffer_reader;

  localparam int N = 1536, LAT = 3, DEPTH = 8, SN = 4, SDEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        done_req, done_ack, rd_en, dout_valid, dout_ready, dout_last, busy;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic [15:0] dout_dr, dout_di;

  logic        s_done_req, s_done_ack, s_rd_en, s_dout_valid, s_dout_ready, s_dout_last, s_busy;
  logic [10:0] s_rd_addr;
  logic [31:0] s_rd_data;
  logic [15:0] s_dout_dr, s_dout_di;

  prach_buffer_reader #(.NUM_SAMPLES(N), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .done_req(done_req), .done_ack(done_ack), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data), .dout_dr(dout_dr), .dout_di(dout_di),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy)
  );

  prach_buffer_reader #(.NUM_SAMPLES(SN), .RD_LATENCY(LAT), .FIFO_DEPTH(SDEPTH)) u_small (
    .clk(clk), .rst(rst), .done_req(s_done_req), .done_ack(s_done_ack), .rd_addr(s_rd_addr),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .dout_dr(s_dout_dr), .dout_di(s_dout_di),
    .dout_valid(s_dout_valid), .dout_ready(s_dout_ready), .dout_last(s_dout_last),
    .busy(s_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Capture buffer contents: dr = index, di = ~index.
  function automatic logic [31:0] mem_word(input logic [10:0] a);
    logic [15:0] x;
    x = {5'b0, a};
    return {~x, x};
  endfunction

  // Fixed-latency buffer read ports.
  logic [31:0] b_pipe [LAT];
  logic [31:0] s_pipe [LAT];
  always @(posedge clk) begin
    b_pipe[0] <= rd_en ? mem_word(rd_addr) : 32'hDEAD_BEEF;
    s_pipe[0] <= s_rd_en ? mem_word(s_rd_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) begin
      b_pipe[i] <= b_pipe[i-1];
      s_pipe[i] <= s_pipe[i-1];
    end
  end
  assign rd_data   = b_pipe[LAT-1];
  assign s_rd_data = s_pipe[LAT-1];

  // Per-frame statistics of the large instance; cleared at each acknowledge.
  int cyc = 0, beats = 0, data_err = 0, addr_err = 0, last_cnt = 0, stall_err = 0;
  int credit_err = 0, ack_err = 0, acks_total = 0, out_cnt = 0, max_out = 0, exp_addr = 0;
  int first_rd = -1, first_valid = -1, first_beat = -1, last_beat = -1;
  logic pv = 1'b0, pr = 1'b0, pbusy = 1'b0;
  logic [32:0] pd = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      out_cnt = 0;
      pv = 1'b0;
      pbusy = 1'b0;
    end else begin
      if (done_ack) begin
        acks_total++;
        if (pbusy) ack_err++;
        beats = 0; data_err = 0; addr_err = 0; last_cnt = 0; stall_err = 0;
        credit_err = 0; max_out = 0; exp_addr = 0;
        first_rd = -1; first_valid = -1; first_beat = -1; last_beat = -1;
      end
      if (rd_en) begin
        if (rd_addr != 11'(exp_addr)) addr_err++;
        exp_addr++;
        out_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (out_cnt > DEPTH) credit_err++;
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (pv && !pr && (!dout_valid || {dout_last, dout_di, dout_dr} != pd)) stall_err++;
      if (dout_valid && dout_ready) begin
        if (dout_dr != 16'(beats) || dout_di != ~16'(beats) || dout_last != (beats == N - 1))
          data_err++;
        if (dout_last) last_cnt++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
        out_cnt--;
      end
      pv = dout_valid;
      pr = dout_ready;
      pd = {dout_last, dout_di, dout_dr};
      pbusy = busy;
    end
  end

  // Small-instance issue tracking.
  int s_issued = 0, s_addr_err = 0, s_acks = 0, s_acc = 0, s_credit_err = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_rd_en) begin
        if (s_rd_addr != 11'(s_issued)) s_addr_err++;
        s_issued++;
      end
      if (s_issued - s_acc > SDEPTH) s_credit_err++;
      if (s_dout_valid && s_dout_ready) s_acc++;
      if (s_done_ack) s_acks++;
    end
  end

  // Runs one frame: mode 0 = ready always high; mode 1 = high until stall_start
  // beats, low for stall_len cycles, then random.
  task automatic run_frame(input int mode, input int stall_start, input int stall_len,
                           input bit keep_req, output bit finished);
    int left;
    bit seen;
    left = stall_len;
    seen = 1'b0;
    finished = 1'b0;
    done_req = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (done_ack && !keep_req) done_req = 1'b0;
      if (mode == 0 || beats < stall_start) dout_ready = 1'b1;
      else if (left > 0) begin
        dout_ready = 1'b0;
        left--;
      end else dout_ready = 1'($urandom_range(0, 1));
      if (busy) seen = 1'b1;
      else if (seen) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int mode;
    int stall_start;
    int stall_len;
    bit keep_req;
    int exp_beats;
    int exp_lat;
    int exp_max_out;
    bit chk_contig;
  } vec_t;

  typedef struct {
    logic [15:0] dr;
    logic [15:0] di;
    logic        last;
  } beat_t;

  vec_t  vecs [5];
  beat_t s_exp [SN];
  beat_t s_got [8];

  initial begin
    bit fin;
    int acks0, nb, s_acc0;

    // Steady state with ready high holds 5 outstanding: 1 in FIFO, 3 in the
    // latency pipe, 1 on the read port. A stall fills all 8 credits.
    vecs[0] = '{0, 0,    0,  1'b0, N, 4, 5, 1'b1};
    vecs[1] = '{1, 300,  50, 1'b0, N, 4, 8, 1'b0};
    vecs[2] = '{0, 0,    0,  1'b1, N, 4, 5, 1'b1};
    vecs[3] = '{0, 0,    0,  1'b0, N, 4, 5, 1'b1};
    vecs[4] = '{1, 1000, 50, 1'b0, N, 4, 8, 1'b0};
    for (int k = 0; k < SN; k++) begin
      s_exp[k].dr   = 16'(k);
      s_exp[k].di   = ~16'(k);
      s_exp[k].last = (k == SN - 1);
    end

    rst = 1'b1;
    done_req = 1'b0;
    dout_ready = 1'b0;
    s_done_req = 1'b0;
    s_dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done_ack", 64'(done_ack), 0);
    check("rst_rd_en", 64'(rd_en), 0);
    check("rst_rd_addr", 64'(rd_addr), 0);
    check("rst_dout_valid", 64'(dout_valid), 0);
    check("rst_dout_last", 64'(dout_last), 0);
    check("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      acks0 = acks_total;
      run_frame(vecs[i].mode, vecs[i].stall_start, vecs[i].stall_len, vecs[i].keep_req, fin);
      check($sformatf("v%0d_finished", i), 64'(fin), 1);
      check($sformatf("v%0d_acks", i), 64'(acks_total - acks0), 1);
      check($sformatf("v%0d_ack_outside_idle", i), 64'(ack_err), 0);
      check($sformatf("v%0d_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
      check($sformatf("v%0d_data", i), 64'(data_err), 0);
      check($sformatf("v%0d_addr", i), 64'(addr_err), 0);
      check($sformatf("v%0d_last_cnt", i), 64'(last_cnt), 1);
      check($sformatf("v%0d_stall_stable", i), 64'(stall_err), 0);
      check($sformatf("v%0d_credit", i), 64'(credit_err), 0);
      check($sformatf("v%0d_max_outstanding", i), 64'(max_out), 64'(vecs[i].exp_max_out));
      check($sformatf("v%0d_latency", i), 64'(first_valid - first_rd), 64'(vecs[i].exp_lat));
      if (vecs[i].chk_contig)
        check($sformatf("v%0d_contiguous", i), 64'(last_beat - first_beat), 64'(N - 1));
      check($sformatf("v%0d_idle_valid", i), 64'(dout_valid), 0);
    end

    // Reset in the middle of a frame, then a fresh frame from address 0.
    done_req = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (done_ack) done_req = 1'b0;
      if (beats >= 700) break;
    end
    check("mid_reached_700", 64'(beats >= 700), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_done_ack", 64'(done_ack), 0);
    check("mid_rst_rd_en", 64'(rd_en), 0);
    check("mid_rst_rd_addr", 64'(rd_addr), 0);
    check("mid_rst_valid", 64'(dout_valid), 0);
    check("mid_rst_last", 64'(dout_last), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_dr", 64'(dout_dr), 0);
    check("mid_rst_di", 64'(dout_di), 0);
    done_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(0, 0, 0, 1'b0, fin);
    check("post_rst_finished", 64'(fin), 1);
    check("post_rst_beats", 64'(beats), 64'(N));
    check("post_rst_addr", 64'(addr_err), 0);
    check("post_rst_data", 64'(data_err), 0);
    check("post_rst_latency", 64'(first_valid - first_rd), 4);

    // Small instance: hold ready low until the 4-entry FIFO is full, then drain.
    s_acc0 = s_acc;
    s_done_req = 1'b1;
    s_dout_ready = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (s_done_ack) s_done_req = 1'b0;
    end
    check("small_acks", 64'(s_acks), 1);
    check("small_issued", 64'(s_issued), 64'(SN));
    check("small_valid_full", 64'(s_dout_valid), 1);
    check("small_busy_stalled", 64'(s_busy), 1);
    check("small_head_dr", 64'(s_dout_dr), 0);
    s_dout_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 50 && s_busy; c++) begin
      if (s_dout_valid && nb < 8) begin
        s_got[nb] = '{s_dout_dr, s_dout_di, s_dout_last};
        nb++;
      end
      @(posedge clk); #1;
    end
    check("small_beats", 64'(nb), 64'(SN));
    check("small_accepted", 64'(s_acc - s_acc0), 64'(SN));
    for (int k = 0; k < SN && k < nb; k++) begin
      check($sformatf("small_b%0d_dr", k), 64'(s_got[k].dr), 64'(s_exp[k].dr));
      check($sformatf("small_b%0d_di", k), 64'(s_got[k].di), 64'(s_exp[k].di));
      check($sformatf("small_b%0d_last", k), 64'(s_got[k].last), 64'(s_exp[k].last));
    end
    check("small_addr", 64'(s_addr_err), 0);
    check("small_credit", 64'(s_credit_err), 0);
    check("small_idle_busy", 64'(s_busy), 0);
    check("small_idle_valid", 64'(s_dout_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
